// File: rtl/bram_fifo_wc.sv
// Single-clock FIFO on inferred block RAM with independent power-of-two write/read widths,
// LSB-first packing/unpacking, first-word-fall-through output stage, level and almost-full.
module bram_fifo_wc #(
  parameter int WR_WIDTH  = 16,
  parameter int RD_WIDTH  = 16,
  parameter int DEPTH     = 256,
  parameter int AF_THRESH = DEPTH - 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [WR_WIDTH-1:0]      wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic [RD_WIDTH-1:0]      rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full
);

  localparam int WW = (WR_WIDTH > RD_WIDTH) ? WR_WIDTH : RD_WIDTH;
  localparam int PR = (RD_WIDTH > WR_WIDTH) ? RD_WIDTH / WR_WIDTH : 1;
  localparam int UR = (WR_WIDTH > RD_WIDTH) ? WR_WIDTH / RD_WIDTH : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AF   = LW'(AF_THRESH);

  logic            clear;
  logic            accept;
  logic            commit;
  logic            consume;
  logic            retire;
  logic            load;
  logic            pack_last_next;
  logic [WW-1:0]   commit_word;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [LW-1:0]   ram_words;
  logic            out_valid_q, out_valid_d;
  logic            wr_ready_q, wr_ready_d;
  logic            af_q, af_d;
  logic [WW-1:0]   out_word_q;
  logic [WW-1:0]   mem [DEPTH];

  assign clear   = reset | flush;
  assign accept  = wr_valid & wr_ready_q & ~clear;
  assign consume = out_valid_q & rd_ready & ~clear;

  generate
    if (PR > 1) begin : g_pack
      localparam int PIW = $clog2(PR);
      localparam logic [PIW-1:0] PACK_LAST = PIW'(PR - 1);
      logic [PIW-1:0]         pack_idx_q, pack_idx_d;
      logic [WW-WR_WIDTH-1:0] pack_reg_q;

      // The final beat bypasses the pack register straight into the RAM write data.
      assign commit         = accept & (pack_idx_q == PACK_LAST);
      assign commit_word    = {wr_data, pack_reg_q};
      assign pack_idx_d     = accept ? pack_idx_q + PIW'(1) : pack_idx_q;
      assign pack_last_next = (pack_idx_d == PACK_LAST);

      always_ff @(posedge clk) begin
        if (clear) begin
          pack_idx_q <= '0;
          pack_reg_q <= '0;
        end else begin
          pack_idx_q <= pack_idx_d;
          if (accept) begin
            for (int i = 0; i < PR - 1; i++) begin
              if (pack_idx_q == PIW'(i)) pack_reg_q[i*WR_WIDTH +: WR_WIDTH] <= wr_data;
            end
          end
        end
      end
    end else begin : g_nopack
      assign commit         = accept;
      assign commit_word    = wr_data;
      assign pack_last_next = 1'b1;
    end

    if (UR > 1) begin : g_unpack
      localparam int UIW = $clog2(UR);
      localparam logic [UIW-1:0] UNPACK_LAST = UIW'(UR - 1);
      logic [UIW-1:0]      unpack_idx_q;
      logic [RD_WIDTH-1:0] slice [UR];

      for (genvar gi = 0; gi < UR; gi++) begin : g_slice
        assign slice[gi] = out_word_q[gi*RD_WIDTH +: RD_WIDTH];
      end

      assign retire  = consume & (unpack_idx_q == UNPACK_LAST);
      assign rd_data = slice[unpack_idx_q];

      always_ff @(posedge clk) begin
        if (clear || load) begin
          unpack_idx_q <= '0;
        end else if (consume) begin
          unpack_idx_q <= unpack_idx_q + UIW'(1);
        end
      end
    end else begin : g_nounpack
      assign retire  = consume;
      assign rd_data = out_word_q;
    end
  endgenerate

  // Words still in RAM are everything committed minus the one parked in the output stage.
  always_comb begin
    ram_words   = level_q - LW'(out_valid_q);
    load        = (ram_words != '0) && (!out_valid_q || retire) && !clear;
    wr_ptr_d    = commit ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = load ? rd_ptr_q + AW'(1) : rd_ptr_q;
    out_valid_d = out_valid_q;
    if (load) begin
      out_valid_d = 1'b1;
    end else if (retire) begin
      out_valid_d = 1'b0;
    end
    level_d    = level_q + LW'(commit) - LW'(retire);
    wr_ready_d = !((level_d == LVL_FULL) && pack_last_next);
    af_d       = (level_d >= LVL_AF);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      wr_ready_q  <= 1'b1;
      af_q        <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      wr_ready_q  <= wr_ready_d;
      af_q        <= af_d;
    end
  end

  always_ff @(posedge clk) begin
    if (commit) mem[wr_ptr_q] <= commit_word;
  end

  // The RAM read register doubles as the output stage, holding while not reloaded.
  always_ff @(posedge clk) begin
    if (clear) begin
      out_word_q <= '0;
    end else if (load) begin
      out_word_q <= mem[rd_ptr_q];
    end
  end

  assign wr_ready    = wr_ready_q & ~clear;
  assign rd_valid    = out_valid_q;
  assign level       = level_q;
  assign almost_full = af_q;

endmodule

// File: tb/tb_bram_fifo_wc.sv
// Bench for bram_fifo_wc: three width configurations checked every cycle against a
// queue-based reference model, plus directed scenarios with hand-computed expectations.
module tb_bram_fifo_wc;

  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int WRS [3] = '{16, 4, 16};
  localparam int RDS [3] = '{16, 16, 4};
  localparam int PRS [3] = '{1, 4, 1};
  localparam int URS [3] = '{1, 1, 4};

  logic        clk;
  logic        rst;
  logic        fl;
  logic [15:0] wd     [3];
  logic        wv     [3];
  logic        rr     [3];
  logic        wr_rdy [3];
  logic        rd_vld [3];
  logic        afl    [3];
  logic [4:0]  lvl    [3];
  logic [15:0] rdata  [3];
  logic [3:0]  rd_c;

  assign rdata[2] = {12'h000, rd_c};

  bram_fifo_wc #(.WR_WIDTH(16), .RD_WIDTH(16), .DEPTH(DEPTH), .AF_THRESH(AF)) u_a (
    .clk(clk), .reset(rst), .flush(fl),
    .wr_data(wd[0]), .wr_valid(wv[0]), .wr_ready(wr_rdy[0]),
    .rd_data(rdata[0]), .rd_valid(rd_vld[0]), .rd_ready(rr[0]),
    .level(lvl[0]), .almost_full(afl[0]));

  bram_fifo_wc #(.WR_WIDTH(4), .RD_WIDTH(16), .DEPTH(DEPTH)) u_b (
    .clk(clk), .reset(rst), .flush(fl),
    .wr_data(wd[1][3:0]), .wr_valid(wv[1]), .wr_ready(wr_rdy[1]),
    .rd_data(rdata[1]), .rd_valid(rd_vld[1]), .rd_ready(rr[1]),
    .level(lvl[1]), .almost_full(afl[1]));

  bram_fifo_wc #(.WR_WIDTH(16), .RD_WIDTH(4), .DEPTH(DEPTH)) u_c (
    .clk(clk), .reset(rst), .flush(fl),
    .wr_data(wd[2]), .wr_valid(wv[2]), .wr_ready(wr_rdy[2]),
    .rd_data(rd_c), .rd_valid(rd_vld[2]), .rd_ready(rr[2]),
    .level(lvl[2]), .almost_full(afl[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit en     = 1'b0;

  // Reference model: committed wide words with the cycle they become visible in level.
  logic [15:0] wq [3][$];
  int          wt [3][$];
  int          pk [3];
  int          uc [3];
  logic [15:0] pacc [3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_step();
    logic clr;
    int   l;
    logic ewr;
    logic ev;
    int   ed;
    int   wmask;
    int   rmask;
    clr = rst | fl;
    for (int k = 0; k < 3; k++) begin
      l     = wq[k].size();
      wmask = (1 << WRS[k]) - 1;
      rmask = (1 << RDS[k]) - 1;
      ewr   = !clr && !(l == DEPTH && pk[k] == PRS[k] - 1);
      ev    = 1'b0;
      ed    = 0;
      if (l > 0) begin
        ev = (wt[k][0] < cyc);
        ed = (int'(wq[k][0]) >> (uc[k] * RDS[k])) & rmask;
      end
      if (en) begin
        chk($sformatf("k%0d.level@%0d", k, cyc), 32'(lvl[k]), 32'(l));
        chk($sformatf("k%0d.wr_ready@%0d", k, cyc), 32'(wr_rdy[k]), 32'(ewr));
        chk($sformatf("k%0d.rd_valid@%0d", k, cyc), 32'(rd_vld[k]), 32'(ev));
        chk($sformatf("k%0d.almost_full@%0d", k, cyc), 32'(afl[k]), 32'(l >= AF));
        if (ev) chk($sformatf("k%0d.rd_data@%0d", k, cyc), 32'(rdata[k]), 32'(ed));
      end
      if (clr) begin
        wq[k].delete();
        wt[k].delete();
        pk[k]   = 0;
        uc[k]   = 0;
        pacc[k] = '0;
      end else begin
        if (ev && rr[k]) begin
          uc[k]++;
          if (uc[k] == URS[k]) begin
            void'(wq[k].pop_front());
            void'(wt[k].pop_front());
            uc[k] = 0;
          end
        end
        if (wv[k] && ewr) begin
          pacc[k] = pacc[k] | 16'((int'(wd[k]) & wmask) << (pk[k] * WRS[k]));
          pk[k]++;
          if (pk[k] == PRS[k]) begin
            wq[k].push_back(pacc[k]);
            wt[k].push_back(cyc + 1);
            pk[k]   = 0;
            pacc[k] = '0;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      wv[k] = 1'b0;
      rr[k] = 1'b0;
    end
  endtask

  int pw [4] = '{90, 30, 60, 100};
  int pr [4] = '{20, 90, 60, 100};

  initial begin
    rst = 1'b1;
    fl  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wd[k] = '0; pk[k] = 0; uc[k] = 0; pacc[k] = '0;
    end
    idle_all();
    tick();
    en = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("k%0d.reset_wr_ready", k), 32'(wr_rdy[k]), 32'd1);
      chk($sformatf("k%0d.reset_level", k), 32'(lvl[k]), 32'd0);
      chk($sformatf("k%0d.reset_rd_valid", k), 32'(rd_vld[k]), 32'd0);
      chk($sformatf("k%0d.reset_rd_data", k), 32'(rdata[k]), 32'd0);
    end
    repeat (3) tick();

    // Single word latency on the 16/16 instance.
    wd[0] = 16'h1234; wv[0] = 1'b1;
    tick();
    wv[0] = 1'b0;
    chk("a.lat_level1", 32'(lvl[0]), 32'd1);
    chk("a.lat_valid_early", 32'(rd_vld[0]), 32'd0);
    tick();
    chk("a.lat_valid", 32'(rd_vld[0]), 32'd1);
    chk("a.lat_data", 32'(rdata[0]), 32'h1234);
    rr[0] = 1'b1;
    tick();
    rr[0] = 1'b0;
    chk("a.lat_level0", 32'(lvl[0]), 32'd0);

    // Fill to full, then stream through pointer wrap.
    for (int i = 0; i < 16; i++) begin
      wd[0] = 16'(i); wv[0] = 1'b1;
      tick();
      chk($sformatf("a.fill_af%0d", i + 1), 32'(afl[0]), 32'(i + 1 >= 14));
    end
    chk("a.full_level", 32'(lvl[0]), 32'd16);
    chk("a.full_wr_ready", 32'(wr_rdy[0]), 32'd0);
    rr[0] = 1'b1;
    for (int i = 16; i < 56; i++) begin
      wd[0] = 16'(i);
      tick();
      chk($sformatf("a.stream_level%0d", i), 32'(lvl[0] >= 15 && lvl[0] <= 16), 32'd1);
    end
    wv[0] = 1'b0;
    repeat (20) tick();
    rr[0] = 1'b0;
    chk("a.drained", 32'(lvl[0]), 32'd0);

    // Packing 4 -> 16: three beats are not a word.
    wv[1] = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      wd[1] = 16'(i);
      tick();
    end
    wv[1] = 1'b0;
    repeat (3) tick();
    chk("b.partial_valid", 32'(rd_vld[1]), 32'd0);
    chk("b.partial_level", 32'(lvl[1]), 32'd0);
    wd[1] = 16'h4; wv[1] = 1'b1;
    tick();
    wv[1] = 1'b0;
    tick();
    chk("b.pack_valid", 32'(rd_vld[1]), 32'd1);
    chk("b.pack_data", 32'(rdata[1]), 32'h4321);
    rr[1] = 1'b1;
    tick();
    rr[1] = 1'b0;

    // Unpacking 16 -> 4.
    wd[2] = 16'hABCD; wv[2] = 1'b1;
    tick();
    wv[2] = 1'b0;
    tick();
    rr[2] = 1'b1;
    chk("c.beat0", 32'(rdata[2]), 32'hD);
    chk("c.level_b0", 32'(lvl[2]), 32'd1);
    tick();
    chk("c.beat1", 32'(rdata[2]), 32'hC);
    tick();
    chk("c.beat2", 32'(rdata[2]), 32'hB);
    tick();
    chk("c.beat3", 32'(rdata[2]), 32'hA);
    chk("c.level_b3", 32'(lvl[2]), 32'd1);
    tick();
    rr[2] = 1'b0;
    chk("c.level_after", 32'(lvl[2]), 32'd0);
    chk("c.valid_after", 32'(rd_vld[2]), 32'd0);

    // Flush discards a partial pack and any beat offered during it.
    wv[1] = 1'b1;
    wd[1] = 16'h1; tick();
    wd[1] = 16'h2; tick();
    fl = 1'b1; wd[1] = 16'hF;
    #1;
    chk("b.flush_wr_ready", 32'(wr_rdy[1]), 32'd0);
    chk("b.flush_level", 32'(lvl[1]), 32'd0);
    chk("b.flush_valid", 32'(rd_vld[1]), 32'd0);
    tick();
    fl = 1'b0;
    for (int i = 5; i <= 8; i++) begin
      wd[1] = 16'(i);
      tick();
    end
    wv[1] = 1'b0;
    tick();
    tick();
    chk("b.after_flush_valid", 32'(rd_vld[1]), 32'd1);
    chk("b.after_flush_data", 32'(rdata[1]), 32'h8765);
    rr[1] = 1'b1;
    tick();
    rr[1] = 1'b0;

    // Reset mid-stream with five words held.
    wv[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wd[0] = 16'h0A0 + 16'(i);
      tick();
    end
    wv[0] = 1'b0;
    tick();
    chk("a.held5", 32'(lvl[0]), 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("a.rst_level", 32'(lvl[0]), 32'd0);
    chk("a.rst_valid", 32'(rd_vld[0]), 32'd0);
    chk("a.rst_af", 32'(afl[0]), 32'd0);
    repeat (4) tick();
    chk("a.no_stale", 32'(rd_vld[0]), 32'd0);

    // Randomised traffic on all three instances.
    for (int n = 0; n < 2400; n++) begin
      for (int k = 0; k < 3; k++) begin
        wv[k] = ($urandom_range(0, 99) < pw[(n / 300) % 4]);
        rr[k] = ($urandom_range(0, 99) < pr[(n / 300) % 4]);
        wd[k] = 16'($urandom);
      end
      fl  = ($urandom_range(0, 199) == 0);
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    fl  = 1'b0;
    rst = 1'b0;
    idle_all();
    for (int k = 0; k < 3; k++) rr[k] = 1'b1;
    repeat (80) tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("k%0d.final_empty", k), 32'(lvl[k]), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
